tt_pin_vector_driver: RTL and testbench

- Host-side driver for a TinyTapeout user project: the opposite end of the pin interface (ui_in/uio_in driven, uo_out/uio_out/uio_oe sampled).
- Accepts a stream of stimulus/expectation vectors over a valid/ready handshake, applies each vector to the design's pins for a programmable number of cycles, then compares masked outputs.
- Sits beside the user project in on-chip self-test and bring-up harnesses. Reports pass/fail, error count and first failing vector index.

---
 rtl/tt_pin_vector_driver.sv | 166 ++++++++++++++++
 tb/tb_tt_pin_vector_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_pin_vector_driver.sv
// Host-side TinyTapeout pin driver: applies stimulus vectors, compares masked uo_out (TT_PIN_VECTOR_UIO_CHECK_EN adds uio checks).
// Latency: RST_CYCLES reset cycles, then 1 fetch cycle + hold+1 stimulus cycles per vector; compare registered at end of hold.
// Backpressure: vec_ready is high only in FETCH, so a producer stalls for the whole hold window of the current vector.
module tt_pin_vector_driver #(
    parameter int HOLD_W     = 4,
    parameter int ERR_W      = 8,
    parameter int RST_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              vec_valid,
    output logic              vec_ready,
    input  logic [7:0]        vec_ui,
    input  logic [7:0]        vec_uio,
    input  logic [7:0]        vec_exp,
    input  logic [7:0]        vec_mask,
    input  logic [HOLD_W-1:0] vec_hold,
    input  logic              vec_last,
    output logic [7:0]        dut_ui_in,
    output logic [7:0]        dut_uio_in,
    output logic              dut_ena,
    output logic              dut_rst_n,
    input  logic [7:0]        dut_uo_out,
    input  logic [7:0]        dut_uio_out,
    input  logic [7:0]        dut_uio_oe,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [7:0]        fail_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_FETCH,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state;
    logic [7:0]        rst_cnt;
    logic [7:0]        vec_idx;
    logic [7:0]        exp_q;
    logic [7:0]        mask_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              last_q;
    logic              fail_seen;

    logic              uo_mis;
    logic              uio_mis;
    logic              mismatch;
    logic              err_sat;

    assign vec_ready = (state == S_FETCH);

    assign uo_mis = |((dut_uo_out ^ exp_q) & mask_q);

`ifdef TT_PIN_VECTOR_UIO_CHECK_EN
    // Driven uio bits must echo the stimulus byte; the uo mask does not apply here.
    assign uio_mis = |((dut_uio_out ^ dut_uio_in) & dut_uio_oe);
`else
    logic unused_uio;
    assign unused_uio = ^{dut_uio_out, dut_uio_oe};
    assign uio_mis    = 1'b0;
`endif

    assign mismatch = uo_mis | uio_mis;
    assign err_sat  = (err_count == {ERR_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rst_cnt    <= '0;
            vec_idx    <= '0;
            exp_q      <= '0;
            mask_q     <= '0;
            hold_q     <= '0;
            hold_cnt   <= '0;
            last_q     <= 1'b0;
            fail_seen  <= 1'b0;
            dut_ui_in  <= '0;
            dut_uio_in <= '0;
            dut_ena    <= 1'b0;
            dut_rst_n  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_idx   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_count  <= '0;
                        fail_idx   <= '0;
                        vec_idx    <= '0;
                        fail_seen  <= 1'b0;
                        rst_cnt    <= '0;
                        dut_ui_in  <= '0;
                        dut_uio_in <= '0;
                        dut_ena    <= 1'b1;
                        dut_rst_n  <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        state      <= S_RESET;
                    end
                end

                S_RESET: begin
                    if (rst_cnt == 8'(RST_CYCLES - 1)) begin
                        dut_rst_n <= 1'b1;
                        state     <= S_FETCH;
                    end else begin
                        rst_cnt <= rst_cnt + 8'd1;
                    end
                end

                S_FETCH: begin
                    if (vec_valid) begin
                        dut_ui_in  <= vec_ui;
                        dut_uio_in <= vec_uio;
                        exp_q      <= vec_exp;
                        mask_q     <= vec_mask;
                        hold_q     <= vec_hold;
                        last_q     <= vec_last;
                        hold_cnt   <= '0;
                        state      <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (hold_cnt == hold_q) begin
                        if (mismatch) begin
                            if (!err_sat) begin
                                err_count <= err_count + 1'b1;
                            end
                            if (!fail_seen) begin
                                fail_idx  <= vec_idx;
                                fail_seen <= 1'b1;
                            end
                        end
                        vec_idx <= vec_idx + 8'd1;
                        if (last_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            // err_count not yet updated this edge, so fold in the final compare.
                            pass  <= !mismatch && (err_count == '0);
                            state <= S_DONE;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_pin_vector_driver.sv
// Directed-vector bench for tt_pin_vector_driver; the user project is modelled as uo_out = ~ui_in.
module tb_tt_pin_vector_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       vec_valid = 1'b0;
    logic       vec_ready;
    logic [7:0] vec_ui = '0;
    logic [7:0] vec_uio = '0;
    logic [7:0] vec_exp = '0;
    logic [7:0] vec_mask = '0;
    logic [3:0] vec_hold = '0;
    logic       vec_last = 1'b0;
    logic [7:0] dut_ui_in;
    logic [7:0] dut_uio_in;
    logic       dut_ena;
    logic       dut_rst_n;
    logic [7:0] dut_uo_out;
    logic [7:0] dut_uio_out = '0;
    logic [7:0] dut_uio_oe = '0;
    logic       busy;
    logic       done;
    logic       pass;
    logic [1:0] err_count;
    logic [7:0] fail_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dut_uo_out = ~dut_ui_in;

    tt_pin_vector_driver #(
        .HOLD_W    (4),
        .ERR_W     (2),
        .RST_CYCLES(4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_ui     (vec_ui),
        .vec_uio    (vec_uio),
        .vec_exp    (vec_exp),
        .vec_mask   (vec_mask),
        .vec_hold   (vec_hold),
        .vec_last   (vec_last),
        .dut_ui_in  (dut_ui_in),
        .dut_uio_in (dut_uio_in),
        .dut_ena    (dut_ena),
        .dut_rst_n  (dut_rst_n),
        .dut_uo_out (dut_uo_out),
        .dut_uio_out(dut_uio_out),
        .dut_uio_oe (dut_uio_oe),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_idx   (fail_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input string tag);
        int lo_cycles;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_done_low"}, 32'(done), 32'd0);
        lo_cycles = 0;
        while (dut_rst_n == 1'b0 && lo_cycles < 20) begin
            if (vec_ready) check({tag, "_ready_in_reset"}, 32'(vec_ready), 32'd0);
            lo_cycles++;
            tick();
        end
        check({tag, "_rst_cycles"}, 32'(lo_cycles), 32'd4);
        check({tag, "_ena"}, 32'(dut_ena), 32'd1);
        check({tag, "_ready_after_rst"}, 32'(vec_ready), 32'd1);
    endtask

    task automatic send_vec(input string tag, input logic [7:0] ui, input logic [7:0] uio,
                            input logic [7:0] ex, input logic [7:0] mk, input logic [3:0] hd,
                            input logic lst, input int gap, input logic [7:0] prev_ui);
        int wait_cyc;
        for (int g = 0; g < gap; g++) begin
            check({tag, "_gap_pins"}, 32'(dut_ui_in), 32'(prev_ui));
            tick();
        end
        vec_ui    = ui;
        vec_uio   = uio;
        vec_exp   = ex;
        vec_mask  = mk;
        vec_hold  = hd;
        vec_last  = lst;
        vec_valid = 1'b1;
        wait_cyc  = 0;
        while (!vec_ready && wait_cyc < 32) begin
            wait_cyc++;
            tick();
        end
        if (!vec_ready) check({tag, "_ready_timeout"}, 32'(vec_ready), 32'd1);
        tick();
        vec_valid = 1'b0;
        for (int k = 0; k <= int'(hd); k++) begin
            check({tag, "_ui_pins"}, 32'(dut_ui_in), 32'(ui));
            check({tag, "_uio_pins"}, 32'(dut_uio_in), 32'(uio));
            if (vec_ready) check({tag, "_ready_in_hold"}, 32'(vec_ready), 32'd0);
            tick();
        end
        if (lst) check({tag, "_done_after"}, 32'(done), 32'd1);
        else     check({tag, "_ready_after"}, 32'(vec_ready), 32'd1);
    endtask

    initial begin
        logic exp_uio_pass;

        repeat (3) tick();
        check("rst_rst_n", 32'(dut_rst_n), 32'd0);
        check("rst_ena", 32'(dut_ena), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outs", {dut_ui_in, dut_uio_in, fail_idx, 6'd0, err_count}, 32'd0);
        check("rst_flags", {29'd0, done, pass, vec_ready}, 32'd0);
        rst = 1'b0;
        tick();

        // Single passing vector held for 3 cycles.
        do_start("t1");
        send_vec("t1v0", 8'h5A, 8'h00, 8'hA5, 8'hFF, 4'd2, 1'b1, 0, 8'h00);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_err", 32'(err_count), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_fail_idx", 32'(fail_idx), 32'd0);
        tick();
        check("t1_done_hold_pins", 32'(dut_ui_in), 32'h5A);
        check("t1_done_rst_n", 32'(dut_rst_n), 32'd1);
        check("t1_done_ena", 32'(dut_ena), 32'd1);

        // Masked pass then a failing vector at index 2.
        do_start("t2");
        send_vec("t2v0", 8'h5A, 8'h00, 8'hA5, 8'hFF, 4'd0, 1'b0, 0, 8'h00);
        send_vec("t2v1", 8'hF0, 8'h00, 8'h00, 8'hF0, 4'd1, 1'b0, 2, 8'h5A);
        send_vec("t2v2", 8'hFE, 8'h00, 8'h00, 8'h01, 4'd0, 1'b1, 1, 8'hF0);
        check("t2_err", 32'(err_count), 32'd1);
        check("t2_fail_idx", 32'(fail_idx), 32'd2);
        check("t2_pass", 32'(pass), 32'd0);

        // Five failures saturate a 2-bit counter.
        do_start("t3");
        for (int i = 0; i < 5; i++)
            send_vec("t3v", 8'h00, 8'h00, 8'h00, 8'hFF, 4'd0, (i == 4), 0, 8'h00);
        check("t3_err_sat", 32'(err_count), 32'd3);
        check("t3_fail_idx", 32'(fail_idx), 32'd0);
        check("t3_pass", 32'(pass), 32'd0);

        // start ignored in HOLD, then async reset mid-hold.
        do_start("t4");
        vec_ui = 8'h3C; vec_uio = 8'h00; vec_exp = 8'hC3; vec_mask = 8'hFF;
        vec_hold = 4'd6; vec_last = 1'b0; vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t4_busy_kept", 32'(busy), 32'd1);
        check("t4_rst_n_kept", 32'(dut_rst_n), 32'd1);
        check("t4_pins_kept", 32'(dut_ui_in), 32'h3C);
        check("t4_ready_low", 32'(vec_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("t4_arst_busy", 32'(busy), 32'd0);
        check("t4_arst_pins", {dut_ui_in, dut_uio_in, 6'd0, err_count, fail_idx}, 32'd0);
        check("t4_arst_ctl", {28'd0, dut_ena, dut_rst_n, done, pass}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // uio echo check on driven bits only.
        dut_uio_oe  = 8'h0F;
        dut_uio_out = 8'h03;
`ifdef TT_PIN_VECTOR_UIO_CHECK_EN
        exp_uio_pass = 1'b0;
`else
        exp_uio_pass = 1'b1;
`endif
        do_start("t5");
        send_vec("t5v0", 8'h11, 8'h07, 8'h00, 8'h00, 4'd1, 1'b1, 0, 8'h00);
        check("t5_pass", 32'(pass), 32'(exp_uio_pass));
        check("t5_err", 32'(err_count), exp_uio_pass ? 32'd0 : 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
